// File: rtl/som_weight_update_if.sv
// ---------------------------------------------------------------------------
// som_weight_update_if
//   Bundles the control, neighbourhood-stage and weight-memory signals of the
//   SOM weight-update stage.
//
//   slave  : the weight-update stage itself
//   master : its environment (pass controller, neighbourhood stage, weight RAM)
//
//   start/winner_in/x_in   pass request, winner coordinate, input vector
//   coordinate_i/_c, S     neuron/winner coordinate out, shift back
//   USS_ctrl               forces the neighbourhood stage to S=15
//   w_rd_*                 weight read port (data one cycle after address)
//   w_wr_*                 weight write port
//   busy/done              pass status
// ---------------------------------------------------------------------------
interface som_weight_update_if #(
    parameter int DIM = 4,
    parameter int W   = 8
);
    logic               start;
    logic [3:0]         winner_in;
    logic [DIM*W-1:0]   x_in;
    logic [3:0]         coordinate_i;
    logic [3:0]         coordinate_c;
    logic               USS_ctrl;
    logic [3:0]         S;
    logic [3:0]         w_rd_addr;
    logic [DIM*W-1:0]   w_rd_data;
    logic               w_wr_en;
    logic [3:0]         w_wr_addr;
    logic [DIM*W-1:0]   w_wr_data;
    logic               busy;
    logic               done;

    modport slave (
        input  start, winner_in, x_in, S, w_rd_data,
        output coordinate_i, coordinate_c, USS_ctrl,
               w_rd_addr, w_wr_en, w_wr_addr, w_wr_data, busy, done
    );

    modport master (
        output start, winner_in, x_in, S, w_rd_data,
        input  coordinate_i, coordinate_c, USS_ctrl,
               w_rd_addr, w_wr_en, w_wr_addr, w_wr_data, busy, done
    );
endinterface

// File: rtl/som_weight_update.sv
// ---------------------------------------------------------------------------
// som_weight_update
//   Sequential weight update of a 4x4 SOM. On start the winner coordinate and
//   input vector are latched, then neurons 0..15 are visited in order, three
//   cycles each (RD, UPD, WR). Each neuron's weights are replaced with
//   w + ((x - w) >>> S), where S comes back combinationally from the
//   neighbourhood stage. S >= W means the neuron is outside the neighbourhood
//   and nothing is written.
//
//   clk, rst : clock, synchronous active-high reset
//   bus      : som_weight_update_if.slave (see interface file for signals)
// ---------------------------------------------------------------------------
module som_weight_update #(
    parameter int DIM = 4,
    parameter int W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    som_weight_update_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        UPD  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [3:0]         idx_reg;
    logic [3:0]         coord_c_reg;
    logic [DIM*W-1:0]   x_reg;
    logic               wr_en_reg;
    logic [3:0]         wr_addr_reg;
    logic [DIM*W-1:0]   wr_data_reg;
    logic [DIM*W-1:0]   new_vec;
    logic               write_ok;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        bus.USS_ctrl = 1'b1;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = RD;
                end
            end
            RD: begin
                state_next   = UPD;
                bus.USS_ctrl = 1'b0;
                bus.busy     = 1'b1;
            end
            UPD: begin
                state_next   = WR;
                bus.USS_ctrl = 1'b0;
                bus.busy     = 1'b1;
            end
            WR: begin
                state_next   = (idx_reg == 4'd15) ? DONE : RD;
                bus.USS_ctrl = 1'b0;
                bus.busy     = 1'b1;
            end
            DONE: begin
                state_next = IDLE;
                bus.done   = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-element update. diff is W+1 bits signed so x - w never overflows;
    // the arithmetic shift floors toward -inf, so the result always lies
    // between w and x and the final truncation to W bits is exact.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_elem
            logic [W-1:0]     x_k;
            logic [W-1:0]     w_k;
            logic signed [W:0] diff_k;
            logic signed [W:0] delta_k;

            assign x_k     = x_reg[gi*W +: W];
            assign w_k     = bus.w_rd_data[gi*W +: W];
            assign diff_k  = $signed({1'b0, x_k}) - $signed({1'b0, w_k});
            assign delta_k = diff_k >>> bus.S;
            assign new_vec[gi*W +: W] = W'({1'b0, w_k} + delta_k);
        end
    endgenerate

    // S is only meaningful in UPD; it is consumed at the end of that cycle,
    // both for the data and for the write/no-write decision.
    assign write_ok = (32'(bus.S) < 32'(W));

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg     <= 4'd0;
            coord_c_reg <= 4'd0;
            x_reg       <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= 4'd0;
            wr_data_reg <= '0;
        end else begin
            // Write strobe lives exactly for the WR cycle.
            wr_en_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        coord_c_reg <= bus.winner_in;
                        x_reg       <= bus.x_in;
                        idx_reg     <= 4'd0;
                    end
                end
                UPD: begin
                    wr_en_reg   <= write_ok;
                    wr_addr_reg <= idx_reg;
                    wr_data_reg <= new_vec;
                end
                WR: begin
                    if (idx_reg != 4'd15) begin
                        idx_reg <= idx_reg + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.coordinate_i = idx_reg;
    assign bus.coordinate_c = coord_c_reg;
    assign bus.w_rd_addr    = idx_reg;
    assign bus.w_wr_en      = wr_en_reg;
    assign bus.w_wr_addr    = wr_addr_reg;
    assign bus.w_wr_data    = wr_data_reg;

endmodule
